// File: rtl/aline_capture_buffer.sv
//------------------------------------------------------------------------------
// Module   : aline_capture_buffer
// Purpose  : Captures a fixed-length burst of ADC samples after each A-line
//            fire and streams it byte-wise to a UART transmitter:
//            header {4'hA, aline}, then each sample as HI byte and LO byte.
//            mem_clear is raised once the buffer has been fully drained.
// Optional : `define ALINE_CAPTURE_CHECKSUM_EN appends one XOR checksum byte
//            covering every byte sent in the A-line (header included).
// Ports    : clk, rst (async, active-high)
//            afe_switch, current_aline  - arm source (rising edge) / index
//            adc_data, adc_valid        - sample input
//            tx_data, tx_valid, tx_ready - byte stream (valid/ready)
//            mem_clear, capturing       - status
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aline_capture_buffer #(
    parameter int SAMPLE_WIDTH = 10,
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    afe_switch,
    input  logic [3:0]              current_aline,
    input  logic [SAMPLE_WIDTH-1:0] adc_data,
    input  logic                    adc_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    mem_clear,
    output logic                    capturing
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CAPTURE  = 3'd1,
        HEADER   = 3'd2,
        FETCH    = 3'd3,
        SEND_HI  = 3'd4,
        SEND_LO  = 3'd5
`ifdef ALINE_CAPTURE_CHECKSUM_EN
        ,
        CHECKSUM = 3'd6
`endif
    } state_t;

    state_t                  state_q;
    logic                    sw_q;
    logic [ADDR_W-1:0]       wr_ptr_q;
    logic [ADDR_W-1:0]       rd_ptr_q;
    logic [3:0]              aline_q;
    logic                    tx_valid_q;
    logic                    mem_clear_q;
    logic                    capturing_q;
    logic [SAMPLE_WIDTH-1:0] sample_q;
    logic [SAMPLE_WIDTH-1:0] mem_q [DEPTH];
`ifdef ALINE_CAPTURE_CHECKSUM_EN
    logic [7:0]              csum_q;
`endif

    logic       arm;
    logic       xfer;
    logic [15:0] sample_ext;
    logic [7:0] tx_byte;

    // sw_q resets high so a switch already high at reset release never arms.
    assign arm        = afe_switch & ~sw_q;
    assign xfer       = tx_valid_q & tx_ready;
    assign sample_ext = 16'(sample_q);

    // Single-port buffer: written only in CAPTURE, read only in FETCH, so the
    // two never collide. sample_q is the 1-cycle read register and holds the
    // sample steady across SEND_HI and SEND_LO.
    always_ff @(posedge clk) begin
        if (state_q == CAPTURE && adc_valid) begin
            mem_q[wr_ptr_q] <= adc_data;
        end
        if (state_q == FETCH) begin
            sample_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sw_q        <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            aline_q     <= 4'h0;
            tx_valid_q  <= 1'b0;
            mem_clear_q <= 1'b1;
            capturing_q <= 1'b0;
`ifdef ALINE_CAPTURE_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            sw_q <= afe_switch;
`ifdef ALINE_CAPTURE_CHECKSUM_EN
            if (xfer) begin
                csum_q <= csum_q ^ tx_byte;
            end
`endif
            case (state_q)
                IDLE: begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    if (arm) begin
                        aline_q     <= current_aline;
                        state_q     <= CAPTURE;
                        mem_clear_q <= 1'b0;
                        capturing_q <= 1'b1;
`ifdef ALINE_CAPTURE_CHECKSUM_EN
                        csum_q      <= 8'h00;
`endif
                    end
                end
                CAPTURE: begin
                    if (adc_valid) begin
                        // Pointer wraps to 0 on the final write.
                        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                        if (wr_ptr_q == C_LAST_ADDR) begin
                            state_q     <= HEADER;
                            capturing_q <= 1'b0;
                            tx_valid_q  <= 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        state_q    <= FETCH;
                        tx_valid_q <= 1'b0;
                    end
                end
                FETCH: begin
                    state_q    <= SEND_HI;
                    tx_valid_q <= 1'b1;
                end
                SEND_HI: begin
                    if (xfer) begin
                        state_q <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (xfer) begin
                        if (rd_ptr_q == C_LAST_ADDR) begin
                            rd_ptr_q <= '0;
`ifdef ALINE_CAPTURE_CHECKSUM_EN
                            state_q  <= CHECKSUM;
`else
                            state_q     <= IDLE;
                            tx_valid_q  <= 1'b0;
                            mem_clear_q <= 1'b1;
`endif
                        end else begin
                            rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
                            state_q    <= FETCH;
                            tx_valid_q <= 1'b0;
                        end
                    end
                end
`ifdef ALINE_CAPTURE_CHECKSUM_EN
                CHECKSUM: begin
                    if (xfer) begin
                        state_q     <= IDLE;
                        tx_valid_q  <= 1'b0;
                        mem_clear_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q     <= IDLE;
                    tx_valid_q  <= 1'b0;
                    mem_clear_q <= 1'b1;
                    capturing_q <= 1'b0;
                end
            endcase
        end
    end

    // Byte selection depends only on registered state and data, so tx_data
    // is stable for as long as tx_valid is held and has no path from tx_ready.
    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            HEADER:   tx_byte = {4'hA, aline_q};
            SEND_HI:  tx_byte = sample_ext[15:8];
            SEND_LO:  tx_byte = sample_ext[7:0];
`ifdef ALINE_CAPTURE_CHECKSUM_EN
            CHECKSUM: tx_byte = csum_q;
`endif
            default:  tx_byte = 8'h00;
        endcase
    end

    assign tx_data   = tx_byte;
    assign tx_valid  = tx_valid_q;
    assign mem_clear = mem_clear_q;
    assign capturing = capturing_q;

endmodule

`default_nettype wire
